// File: rtl/game_pkg.sv
// Shared state encoding, parameter defaults and helpers for the game controller.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_PAUSE = 3'd2,
    S_HIT   = 3'd3,
    S_LVLUP = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  localparam int LIVES_INIT_DEF   = 3;
  localparam int HIT_FRAMES_DEF   = 60;
  localparam int LVLUP_FRAMES_DEF = 30;
  localparam int MAX_LEVEL_DEF    = 15;

  // Frame counts must fit the 8-bit frame counter and be at least one tick.
  function automatic logic [7:0] clamp_frames(input int f);
    if (f < 1) return 8'd1;
    else if (f > 255) return 8'd255;
    else return f[7:0];
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced, synchronous button level.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= btn;
  end

  assign rise = btn & ~prev_q;

endmodule

// File: rtl/game_ctrl.sv
// Game flow controller: start/pause handling, hit and level-up timing,
// lives and level bookkeeping. All outputs are registered.
module game_ctrl #(
  parameter int LIVES_INIT   = game_pkg::LIVES_INIT_DEF,
  parameter int HIT_FRAMES   = game_pkg::HIT_FRAMES_DEF,
  parameter int LVLUP_FRAMES = game_pkg::LVLUP_FRAMES_DEF,
  parameter int MAX_LEVEL    = game_pkg::MAX_LEVEL_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       collide,
  input  logic       goal,
  output logic       run_en,
  output logic       reset_player,
  output logic [3:0] level,
  output logic [1:0] lives,
  output logic [2:0] state,
  output logic       game_over
);
  import game_pkg::*;

  localparam logic [1:0] LIVES_LD  = 2'(LIVES_INIT);
  localparam logic [3:0] LVL_MAX   = 4'(MAX_LEVEL);
  localparam logic [7:0] HIT_LAST  = clamp_frames(HIT_FRAMES) - 8'd1;
  localparam logic [7:0] LVL_LAST  = clamp_frames(LVLUP_FRAMES) - 8'd1;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] level_q, level_d;
  logic [1:0] lives_q, lives_d;
  logic       rp_q, rp_d;
  logic       run_en_q, game_over_q;
  logic       start_rise, pause_rise;
  logic       hit_done, lvl_done;

  btn_edge u_start_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (start_btn),
    .rise  (start_rise)
  );

  btn_edge u_pause_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (pause_btn),
    .rise  (pause_rise)
  );

  // The tick that completes the timed state is the one landing on the last count.
  assign hit_done = frame_tick && (cnt_q == HIT_LAST);
  assign lvl_done = frame_tick && (cnt_q == LVL_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      level_q     <= 4'd0;
      lives_q     <= 2'd0;
      rp_q        <= 1'b0;
      run_en_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      lives_q     <= lives_d;
      rp_q        <= rp_d;
      run_en_q    <= (state_d == S_PLAY);
      game_over_q <= (state_d == S_OVER);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_OVER: if (start_rise) state_d = S_PLAY;
      S_PLAY: begin
        if (collide)         state_d = S_HIT;
        else if (goal)       state_d = S_LVLUP;
        else if (pause_rise) state_d = S_PAUSE;
      end
      S_PAUSE: if (pause_rise) state_d = S_PLAY;
      S_HIT:   if (hit_done) state_d = (lives_q == 2'd0) ? S_OVER : S_PLAY;
      S_LVLUP: if (lvl_done) state_d = S_PLAY;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    lives_d = lives_q;
    rp_d    = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_rise) begin
          level_d = 4'd1;
          lives_d = LIVES_LD;
          rp_d    = 1'b1;
          cnt_d   = 8'd0;
        end
      end
      S_PLAY: begin
        if (collide) begin
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          cnt_d   = 8'd0;
        end else if (goal) begin
          cnt_d = 8'd0;
        end
      end
      S_HIT: begin
        if (hit_done) begin
          cnt_d = 8'd0;
          rp_d  = (lives_q != 2'd0);
        end else if (frame_tick) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_LVLUP: begin
        if (lvl_done) begin
          cnt_d   = 8'd0;
          level_d = (level_q >= LVL_MAX) ? LVL_MAX : level_q + 4'd1;
          rp_d    = 1'b1;
        end else if (frame_tick) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign state        = state_q;
  assign level        = level_q;
  assign lives        = lives_q;
  assign reset_player = rp_q;
  assign run_en       = run_en_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus a randomized run
// compared cycle by cycle against a rule-level model of the game flow.
module tb_game_ctrl;

  localparam int HITF = 60;
  localparam int LVLF = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0, start_btn = 1'b0, pause_btn = 1'b0;
  logic       collide = 1'b0, goal = 1'b0;
  logic       run_en, reset_player, game_over;
  logic [3:0] level;
  logic [1:0] lives;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail = 0;

  // model: game rules written over plain integers
  int m_state, m_level, m_lives, m_frames;
  bit m_rp, m_prev_start, m_prev_pause;

  game_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .start_btn    (start_btn),
    .pause_btn    (pause_btn),
    .collide      (collide),
    .goal         (goal),
    .run_en       (run_en),
    .reset_player (reset_player),
    .level        (level),
    .lives        (lives),
    .state        (state),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_level = 0; m_lives = 0; m_frames = 0;
    m_rp = 0; m_prev_start = 0; m_prev_pause = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit c, input bit g, input bit t);
    bit sr, pr;
    sr = s && !m_prev_start;
    pr = p && !m_prev_pause;
    m_prev_start = s;
    m_prev_pause = p;
    m_rp = 0;
    case (m_state)
      0, 5: if (sr) begin m_state = 1; m_level = 1; m_lives = 3; m_rp = 1; end
      1: begin
        if (c) begin
          m_state = 3; m_frames = 0;
          if (m_lives > 0) m_lives = m_lives - 1;
        end else if (g) begin
          m_state = 4; m_frames = 0;
        end else if (pr) m_state = 2;
      end
      2: if (pr) m_state = 1;
      3: if (t) begin
        m_frames++;
        if (m_frames == HITF) begin
          if (m_lives == 0) m_state = 5;
          else begin m_state = 1; m_rp = 1; end
        end
      end
      4: if (t) begin
        m_frames++;
        if (m_frames == LVLF) begin
          m_level = (m_level + 1 > 15) ? 15 : m_level + 1;
          m_rp = 1; m_state = 1;
        end
      end
      default: m_state = 0;
    endcase
  endtask

  function automatic logic [11:0] model_vec();
    return {3'(m_state), 4'(m_level), 2'(m_lives), (m_state == 1), (m_state == 5), m_rp};
  endfunction

  // Drive one cycle of inputs (called #1 after a posedge), advance model, land #1 after next posedge.
  task automatic step(input bit s, input bit p, input bit c, input bit g, input bit t);
    start_btn = s; pause_btn = p; collide = c; goal = g; frame_tick = t;
    model_step(s, p, c, g, t);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start_btn = 0; pause_btn = 0; collide = 0; goal = 0; frame_tick = 0;
    @(posedge clk); #1;
    model_reset();
    reset = 1'b0;
  endtask

  // n frame ticks with idle gaps; button/collision noise is injected while still in the timed state
  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      step(0, 0, 0, 0, 1);
      if (k < n - 1) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int j = 0; j < gap; j++)
          step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0);
        step(0, 0, 0, 0, 0);
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    do_reset();
    n_checks++;
    if ({state, level, lives, run_en, reset_player, game_over} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got st=%0d lvl=%0d lives=%0d run=%0b rp=%0b go=%0b want all zero",
               state, level, lives, run_en, reset_player, game_over);
    end
  endtask

  task automatic test_start();
    step(1, 0, 0, 0, 0);
    n_checks++;
    if ({state, level, lives, reset_player, run_en} !== {3'd1, 4'd1, 2'd3, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL start_enter got st=%0d lvl=%0d lives=%0d rp=%0b run=%0b want 1/1/3/1/1",
               state, level, lives, reset_player, run_en);
    end
    step(1, 0, 0, 0, 0);
    n_checks++;
    if (reset_player !== 1'b0 || state !== 3'd1) begin
      n_fail++;
      $display("FAIL start_held got rp=%0b st=%0d want rp=0 st=1", reset_player, state);
    end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_hit_recover();
    step(0, 0, 1, 1, 0);
    n_checks++;
    if (state !== 3'd3 || lives !== 2'd2 || run_en !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_entry got st=%0d lives=%0d run=%0b want st=3 lives=2 run=0", state, lives, run_en);
    end
    run_ticks(HITF - 1);
    n_checks++;
    if (state !== 3'd3) begin
      n_fail++;
      $display("FAIL hit_early_exit got st=%0d want 3", state);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (state !== 3'd1 || reset_player !== 1'b1 || lives !== 2'd2) begin
      n_fail++;
      $display("FAIL hit_exit got st=%0d rp=%0b lives=%0d want st=1 rp=1 lives=2", state, reset_player, lives);
    end
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (reset_player !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_rp_width got rp=%0b want 0", reset_player);
    end
  endtask

  task automatic test_game_over();
    step(0, 0, 1, 0, 0);
    run_ticks(HITF);
    step(0, 0, 1, 0, 0);
    n_checks++;
    if (state !== 3'd3 || lives !== 2'd0) begin
      n_fail++;
      $display("FAIL last_life got st=%0d lives=%0d want st=3 lives=0", state, lives);
    end
    run_ticks(HITF);
    n_checks++;
    if (state !== 3'd5 || game_over !== 1'b1 || run_en !== 1'b0 || reset_player !== 1'b0) begin
      n_fail++;
      $display("FAIL game_over got st=%0d go=%0b run=%0b rp=%0b want st=5 go=1 run=0 rp=0",
               state, game_over, run_en, reset_player);
    end
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    n_checks++;
    if (state !== 3'd1 || lives !== 2'd3 || level !== 4'd1 || reset_player !== 1'b1 || game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL restart got st=%0d lives=%0d lvl=%0d rp=%0b go=%0b want 1/3/1/1/0",
               state, lives, level, reset_player, game_over);
    end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_level_sat();
    for (int l = 2; l <= 16; l++) begin
      step(0, 0, 0, 1, 0);
      n_checks++;
      if (state !== 3'd4) begin
        n_fail++;
        $display("FAIL lvlup_entry got st=%0d want 4", state);
      end
      run_ticks(LVLF);
      n_checks++;
      if (state !== 3'd1 || level !== 4'((l > 15) ? 15 : l) || reset_player !== 1'b1) begin
        n_fail++;
        $display("FAIL lvlup_exit got st=%0d lvl=%0d rp=%0b want st=1 lvl=%0d rp=1",
                 state, level, reset_player, (l > 15) ? 15 : l);
      end
      step(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_pause();
    logic [3:0] lvl0;
    logic [1:0] lives0;
    lvl0 = 4'(m_level);
    lives0 = 2'(m_lives);
    step(0, 1, 0, 0, 1);
    n_checks++;
    if (state !== 3'd2 || run_en !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_enter got st=%0d run=%0b want st=2 run=0", state, run_en);
    end
    for (int i = 0; i < 99; i++) step(0, 1, 0, 0, $urandom_range(0, 1));
    n_checks++;
    if (state !== 3'd2 || level !== lvl0 || lives !== lives0) begin
      n_fail++;
      $display("FAIL pause_held got st=%0d lvl=%0d lives=%0d want st=2 lvl=%0d lives=%0d",
               state, level, lives, lvl0, lives0);
    end
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    n_checks++;
    if (state !== 3'd1 || run_en !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_resume got st=%0d run=%0b want st=1 run=1", state, run_en);
    end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_hit();
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1);
    do_reset();
    n_checks++;
    if ({state, level, lives, reset_player, run_en, game_over} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_mid_hit got st=%0d lvl=%0d lives=%0d rp=%0b want all zero",
               state, level, lives, reset_player);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 1));
      n_checks++;
      if ({state, level, lives, run_en, game_over, reset_player} !== model_vec()) begin
        n_fail++;
        $display("FAIL random_cycle%0d got %h want %h", i,
                 {state, level, lives, run_en, game_over, reset_player}, model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_hit_recover();
    test_game_over();
    test_level_sat();
    test_pause();
    test_reset_mid_hit();
    step(1, 0, 0, 0, 0);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter LIVES_INIT, default 3: lives loaded at game start (1..3).
REQ-002 SHALL have parameter HIT_FRAMES, default 60: frame ticks spent in HIT.
REQ-003 SHALL have parameter LVLUP_FRAMES, default 30: frame ticks spent in LVLUP.
REQ-004 SHALL have parameter MAX_LEVEL, default 15: saturation level.
REQ-005 SHALL have port clk  in  1  system clock; one clock only; reset is synchronous and active-high.
REQ-006 SHALL have port reset  in  1  synchronous active-high reset.
REQ-007 SHALL have port frame_tick  in  1  one-cycle pulse per video frame.
REQ-008 SHALL have port start_btn  in  1  debounced, synchronous level.
REQ-009 SHALL have port pause_btn  in  1  debounced, synchronous level.
REQ-010 SHALL have port collide  in  1  player/bar overlap level.
REQ-011 SHALL have port goal  in  1  player reached top row, level.
REQ-012 SHALL have port run_en  out  1  enables player/environment motion.
REQ-013 SHALL have port reset_player  out  1  one-cycle pulse; returns player to spawn.
REQ-014 SHALL have port level  out  4  current level.
REQ-015 SHALL have port lives  out  2  remaining lives.
REQ-016 SHALL have port state  out  3  encoded FSM state.
REQ-017 SHALL have port game_over  out  1  high while in OVER.

Function
REQ-018 SHALL use states IDLE=0, PLAY=1, PAUSE=2, HIT=3, LVLUP=4, OVER=5; codes 6-7 SHALL go to IDLE.
REQ-019 SHALL detect start and pause as rising edges (registered previous value); a held button SHALL act once only.
REQ-020 SHALL register all outputs; a transition SHALL be visible on state the cycle after the causing input is sampled.
REQ-021 IDLE or OVER + start edge -> PLAY; level=1, lives=LIVES_INIT, reset_player pulsed in the same cycle.
REQ-022 PLAY priority: collide > goal > pause edge; simultaneous collide and goal -> HIT only.
REQ-023 PLAY + collide -> HIT; lives decremented on entry (2'd0 never decremented); frame counter cleared.
REQ-024 PLAY + goal -> LVLUP; frame counter cleared.
REQ-025 PLAY + pause edge -> PAUSE; PAUSE + pause edge -> PLAY; counters, level and lives frozen in PAUSE.
REQ-026 HIT and LVLUP SHALL count frame_tick pulses only and ignore pause, start, collide and goal.
REQ-027 HIT, counter reaching HIT_FRAMES: lives==0 -> OVER; else reset_player pulse, -> PLAY.
REQ-028 LVLUP, counter reaching LVLUP_FRAMES: level=min(level+1, MAX_LEVEL); reset_player pulse; -> PLAY.
REQ-029 run_en SHALL be 1 only in PLAY; game_over SHALL be 1 only in OVER.
REQ-030 reset_player SHALL be high for exactly one cycle per event, never two consecutive cycles.
REQ-031 Frame counter SHALL be 8 bits; HIT_FRAMES and LVLUP_FRAMES SHALL be limited to 1..255.

Reset
REQ-032 reset SHALL set: state=IDLE, level=0, lives=0, run_en=0, reset_player=0, game_over=0, counter=0, edge registers=0.
REQ-033 reset SHALL take priority over every input and SHALL act in any state on the next clk edge.

Structure
REQ-034 State encodings and parameter defaults SHALL live in the shared package game_pkg.
REQ-035 Rising-edge detection SHALL be sub-module btn_edge, instantiated twice (start, pause).

Verification
REQ-036 reset, start edge -> state=1, level=1, lives=3, one reset_player pulse, run_en=1.
REQ-037 PLAY, collide and goal high together -> state=3, lives 3->2; after 60 ticks -> state=1, reset_player pulse.
REQ-038 lives=1, collide -> HIT, lives=0; after 60 ticks -> state=5, game_over=1, run_en=0.
REQ-039 level=15, goal -> LVLUP; after 30 ticks -> level stays 15, state=1.
REQ-040 PLAY, pause held 100 cycles -> state=2 once, counters frozen; second edge -> state=1.
REQ-041 reset asserted mid-HIT at tick 20 -> next cycle state=0, level=0, lives=0, reset_player=0.
